// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the instruction ROM and
// buffers one fetched word for decode. Optional counters: IMEM_FETCH_PERF_EN.
//
// state | meaning
// RUN   | fetching sequentially, redirects accepted
// HALT  | all-zero word seen; buffer drains, exit only by reset
// FAULT | illegal PC or redirect target; buffer drains, exit only by reset
module imem_fetch_ctrl #(
    parameter int N = 64,
    parameter int AW = 6,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_q,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [N-1:0]  br_target,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [N-1:0]  inst_pc,
    output logic          halted,
    output logic          fault
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [15:0]   flush_cnt
`endif
);

    localparam logic [N-1:0] MAX_PC  = N'((2 ** AW) * 4 - 4);
    localparam logic [N-1:0] PC_STEP = N'(4);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  pc, pc_nxt;
    logic          valid_nxt;
    logic [31:0]   inst_nxt;
    logic [N-1:0]  inst_pc_nxt;
    logic          xfer, space, br_legal;

    assign xfer      = inst_valid & inst_ready;
    assign space     = ~inst_valid | inst_ready;
    assign br_legal  = (br_target[1:0] == 2'b00) && (br_target <= MAX_PC);
    assign imem_addr = pc[AW+1:2];
    assign halted    = (state == HALT);
    assign fault     = (state == FAULT);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        valid_nxt   = inst_valid & ~xfer;
        inst_nxt    = inst;
        inst_pc_nxt = inst_pc;
        case (state)
            RUN: begin
                if (br_taken && !br_legal) begin
                    state_nxt = FAULT;
                    valid_nxt = 1'b0;
                end else if (br_taken) begin
                    // flush wins over an accept in the same cycle
                    pc_nxt    = br_target;
                    valid_nxt = 1'b0;
                end else if (!stall && space) begin
                    if (imem_q == 32'h0) begin
                        state_nxt = HALT;
                    end else begin
                        inst_nxt    = imem_q;
                        inst_pc_nxt = pc;
                        valid_nxt   = 1'b1;
                        // last ROM word: no wrap, the PC stays put in FAULT
                        if (pc == MAX_PC) state_nxt = FAULT;
                        else              pc_nxt    = pc + PC_STEP;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst_valid <= valid_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic fetch_ev, flush_ev;

    assign fetch_ev = (state == RUN) && !br_taken && !stall && space && (imem_q != 32'h0);
    assign flush_ev = (state == RUN) && br_taken && br_legal && inst_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (fetch_ev && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
            if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus randomized
// traffic compared each cycle against a behavioural fetch model.
module tb_imem_fetch_ctrl;

    typedef logic [104:0] obs_t;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        halted;
    logic        fault;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    logic [31:0] rom [64];
    assign imem_q = rom[imem_addr];

    imem_fetch_ctrl dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .halted(halted), .fault(fault)
`ifdef IMEM_FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = running, 1 = halted, 2 = faulted
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_inst;
    bit          m_valid;
    int          m_mode;
    longint      m_fetch, m_flush;

    task automatic model_step();
        bit take, keep, room;
        logic [31:0] w;
        if (!reset) begin
            m_pc = 0; m_mode = 0; m_valid = 0; m_inst = 0; m_ipc = 0;
            m_fetch = 0; m_flush = 0;
            return;
        end
        take = m_valid && inst_ready;
        keep = m_valid && !take;
        room = !m_valid || inst_ready;
        if (m_mode == 0) begin
            if (br_taken) begin
                if ((br_target % 4 != 0) || (br_target > 64'd252)) begin
                    m_mode = 2;
                end else begin
                    if (m_valid && m_flush < 65535) m_flush++;
                    m_pc = br_target;
                end
                keep = 0;
            end else if (!stall && room) begin
                w = rom[m_pc[7:2]];
                if (w == 0) begin
                    m_mode = 1;
                end else begin
                    m_inst = w; m_ipc = m_pc; keep = 1;
                    if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
                    if (m_pc == 64'd252) m_mode = 2;
                    else m_pc = m_pc + 4;
                end
            end
        end
        m_valid = keep;
    endtask

    function automatic obs_t dut_obs();
        return {inst_valid, inst, inst_pc, imem_addr, halted, fault};
    endfunction

    function automatic obs_t mdl_obs();
        return {m_valid, m_inst, m_ipc, m_pc[7:2], m_mode == 1, m_mode == 2};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 64; i++) rom[i] = $urandom() | 32'h1;
    endtask

    task automatic do_reset();
        reset = 0; stall = 0; br_taken = 0; br_target = 0; inst_ready = 0;
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        fill_rom();
        reset = 1; stall = 0; br_taken = 0; br_target = 0; inst_ready = 0;
        do_reset();
        checks++;
        if ({inst_valid, inst, inst_pc, imem_addr, halted, fault} !== 105'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b inst=%h pc=%h addr=%0d h=%b f=%b want all zero",
                     inst_valid, inst, inst_pc, imem_addr, halted, fault);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        inst_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst !== rom[k] || inst_pc !== 64'(4 * k)) begin
                errors++;
                $display("FAIL seq_fetch[%0d] got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                         k, inst_valid, inst, inst_pc, rom[k], 4 * k);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        do_reset();
        inst_ready = 1;
        repeat (3) tick();
        held = rom[2];
        inst_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst !== held || inst_pc !== 64'h8 || imem_addr !== 6'd3) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got v=%b inst=%h pc=%h addr=%0d want v=1 inst=%h pc=8 addr=3",
                         k, inst_valid, inst, inst_pc, imem_addr, held);
            end
        end
        inst_ready = 1;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst !== rom[3] || inst_pc !== 64'hC) begin
            errors++;
            $display("FAIL backpressure_resume got v=%b inst=%h pc=%h want v=1 inst=%h pc=c",
                     inst_valid, inst, inst_pc, rom[3]);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        inst_ready = 1;
        repeat (5) tick();
        checks++;
        if (inst_pc !== 64'h10 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_setup got v=%b pc=%h want v=1 pc=10", inst_valid, inst_pc);
        end
        br_taken = 1; br_target = 64'h2C;
        tick();
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 6'd11) begin
            errors++;
            $display("FAIL redirect_flush got v=%b addr=%0d want v=0 addr=11", inst_valid, imem_addr);
        end
        br_taken = 0;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst !== rom[11] || inst_pc !== 64'h2C) begin
            errors++;
            $display("FAIL redirect_target got v=%b inst=%h pc=%h want v=1 inst=%h pc=2c",
                     inst_valid, inst, inst_pc, rom[11]);
        end
    endtask

    task automatic test_halt();
        rom[34] = 32'h0;
        do_reset();
        inst_ready = 1; br_taken = 1; br_target = 64'h84;
        tick();
        br_taken = 0;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst !== rom[33] || inst_pc !== 64'h84 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_last_inst got v=%b inst=%h pc=%h h=%b want v=1 inst=%h pc=84 h=0",
                     inst_valid, inst, inst_pc, halted, rom[33]);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter got h=%b v=%b want h=1 v=0", halted, inst_valid);
        end
        br_taken = 1; br_target = 64'h10;
        tick();
        checks++;
        if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 6'd34) begin
            errors++;
            $display("FAIL halt_ignore_branch got h=%b v=%b addr=%0d want h=1 v=0 addr=34",
                     halted, inst_valid, imem_addr);
        end
        br_taken = 0;
        reset = 0;
        tick();
        reset = 1;
        checks++;
        if (halted !== 1'b0 || imem_addr !== 6'd0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset_exit got h=%b addr=%0d v=%b want h=0 addr=0 v=0",
                     halted, imem_addr, inst_valid);
        end
        rom[34] = 32'h3434_0001;
    endtask

    task automatic test_fault();
        do_reset();
        inst_ready = 1; br_taken = 1; br_target = 64'h102;
        tick();
        br_taken = 0;
        checks++;
        if (fault !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_bad_target got f=%b v=%b want f=1 v=0", fault, inst_valid);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_no_fetch got f=%b v=%b want f=1 v=0", fault, inst_valid);
        end
        do_reset();
        inst_ready = 1; br_taken = 1; br_target = 64'hFC;
        tick();
        br_taken = 0;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'hFC || inst !== rom[63] || fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_last_word got v=%b pc=%h inst=%h f=%b want v=1 pc=fc inst=%h f=1",
                     inst_valid, inst_pc, inst, fault, rom[63]);
        end
        repeat (2) tick();
        checks++;
        if (inst_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 6'd63) begin
            errors++;
            $display("FAIL fault_drained got v=%b f=%b addr=%0d want v=0 f=1 addr=63",
                     inst_valid, fault, imem_addr);
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        inst_ready = 1;
        repeat (3) tick();
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b0 || imem_addr !== 6'd3) begin
                errors++;
                $display("FAIL stall_frozen[%0d] got v=%b addr=%0d want v=0 addr=3", k, inst_valid, imem_addr);
            end
        end
        stall = 0; inst_ready = 0;
        repeat (2) tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'hC) begin
            errors++;
            $display("FAIL stall_resume got v=%b pc=%h want v=1 pc=c", inst_valid, inst_pc);
        end
        reset = 0;
        tick();
        reset = 1;
        checks++;
        if ({inst_valid, inst, inst_pc, imem_addr, halted, fault} !== 105'd0) begin
            errors++;
            $display("FAIL midrun_reset got v=%b inst=%h pc=%h addr=%0d h=%b f=%b want all zero",
                     inst_valid, inst, inst_pc, imem_addr, halted, fault);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom() | 32'h1);
        rom[0] = 32'h0000_00A1;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset      = ($urandom_range(0, 49) != 0);
            stall      = ($urandom_range(0, 9) < 3);
            inst_ready = ($urandom_range(0, 9) < 7);
            br_taken   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       br_target = 64'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                1:       br_target = 64'h100 + 64'($urandom_range(0, 63) * 4);
                2:       br_target = {$urandom() | 32'h1, 32'($urandom_range(0, 63) * 4)};
                default: br_target = 64'($urandom_range(0, 63) * 4);
            endcase
            tick();
            checks++;
            if (dut_obs() !== mdl_obs()) begin
                errors++;
                $display("FAIL random_cycle[%0d] got {v,inst,pc,addr,h,f}=%h want %h", cyc, dut_obs(), mdl_obs());
            end
`ifdef IMEM_FETCH_PERF_EN
            checks++;
            if (fetch_cnt !== m_fetch[31:0] || flush_cnt !== m_flush[15:0]) begin
                errors++;
                $display("FAIL random_perf[%0d] got fetch=%0d flush=%0d want fetch=%0d flush=%0d",
                         cyc, fetch_cnt, flush_cnt, m_fetch, m_flush);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_fault();
        test_stall_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 64-word x 32-bit instruction ROM (combinational read, word address addr[5:0]).
- Owns the PC, drives the ROM address and registers the fetched word into a one-entry output buffer with a valid/ready handshake to decode.
- Handles branch redirect with flush, front-end stall, halt on an all-zero word, and a fault on an illegal PC.

Parameters:
- N, 64, PC width in bits.
- AW, 6, ROM word-address width; the legal byte-PC range is 0 .. 4*(2**AW)-4.
- RESET_PC, 0, byte PC loaded on reset. It must be word-aligned and in range.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- imem_addr  out  AW  ROM word address; combinational, equal to pc[AW+1:2].
- imem_q  in  32  ROM read data for imem_addr, valid in the same cycle.
- stall  in  1  front-end stall; no new fetch while 1.
- br_taken  in  1  redirect request, 1-cycle qualifier.
- br_target  in  N  redirect byte PC.
- inst_valid  out  1  output buffer holds an instruction.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  buffered instruction word.
- inst_pc  out  N  byte PC of inst.
- halted  out  1  state == HALT.
- fault  out  1  state == FAULT.

Behaviour:
- State register values: RUN, HALT, FAULT. Internal registers: pc, plus the output buffer (inst_valid, inst, inst_pc).
- Reset (reset==0 at an edge), taking priority over everything including mid-operation:
  - pc=RESET_PC, state=RUN.
  - inst_valid=0, inst=0, inst_pc=0.
  - halted=0, fault=0.
  - The first fetch happens on the first edge with reset==1.
- Transfer: xfer = inst_valid & inst_ready.
- Buffer space: space = ~inst_valid | inst_ready.
- RUN, evaluated in this priority order each edge:
  1. br_taken=1 and br_target is illegal (br_target[1:0]!=0, or br_target > 4*(2**AW)-4):
     - state<=FAULT, inst_valid<=0.
  2. br_taken=1 and br_target is legal:
     - pc<=br_target, inst_valid<=0 (flush, even if the held instruction is being accepted in that cycle).
     - No fetch in this cycle; the first target word is loaded on the next edge, so redirect-to-valid latency is 2 edges.
  3. stall=0, space=1, and imem_q==32'h0:
     - state<=HALT, pc unchanged.
     - inst_valid<=0 if xfer, else it holds.
     - The zero word is never presented.
  4. stall=0, space=1, and imem_q!=0:
     - inst<=imem_q, inst_pc<=pc, inst_valid<=1.
     - If pc==4*(2**AW)-4, state<=FAULT on the same edge (no wrap to 0); the loaded instruction stays valid until accepted. Otherwise pc<=pc+4 (N-bit add).
  5. Otherwise, no fetch:
     - inst_valid<=0 if xfer, else it holds. inst and inst_pc hold.
- Sustained throughput: with stall=0 and inst_ready=1, one instruction per cycle.
- inst and inst_pc are stable while inst_valid=1 and inst_ready=0.
- HALT: br_taken and stall are ignored. No fetch. The buffer drains via xfer. Exit only by reset.
- FAULT: no fetch; br_taken is ignored. The buffer drains via xfer except after case 1 (already flushed). Exit only by reset.
- imem_addr always reflects pc, including in HALT and FAULT.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- When defined, adds two output ports:
  - fetch_cnt (32 bits): +1 on every case-4 load.
  - flush_cnt (16 bits): +1 on every case-2 redirect that discards inst_valid=1.
- Both counters reset to 0, saturate at all-ones, and are frozen in HALT and FAULT.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Sequential fetch: ROM[0..3]=A,B,C,D (non-zero), inst_ready=1, stall=0 after reset release -> inst=A,B,C,D on consecutive cycles with inst_pc=0,4,8,12; first inst_valid one edge after release.
- Backpressure: inst_ready=0 for 3 cycles while inst_valid=1 at inst_pc=8 -> inst and inst_pc hold, imem_addr stays 3; after inst_ready=1, inst_pc=12 follows the next cycle with no loss or duplication.
- Redirect with flush: br_taken=1, br_target=0x2C while inst_valid=1 at inst_pc=0x10 -> next edge inst_valid=0, pc=0x2C; following edge inst=ROM[11], inst_pc=0x2C.
- Halt: ROM[34]=0, run from ROM[33] -> instruction at inst_pc=0x84 delivered, then halted=1, inst_valid=0 after accept; br_taken ignored; reset (reset=0 one edge) returns to pc=0, halted=0.
- Fault: br_target=0x102 -> fault=1, inst_valid=0 next edge; separately, a fetch at pc=0xFC with a non-zero word -> instruction delivered with inst_pc=0xFC, then fault=1 and no further fetch.
- Stall and reset mid-run: stall=1 for 2 cycles -> pc frozen, buffer drains; reset=0 asserted while inst_valid=1 -> next edge all outputs 0, pc=RESET_PC.
